// File: rtl/dr_xfer_ctrl.sv
// dr_xfer_ctrl: sequences a single memory read/write through the 8-bit DR,
// with address setup, ready handshake, bus timeout and done/err reporting.
module dr_xfer_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_rdy,
    output logic              load_dr,
    output logic              dr_oe
);

    localparam int unsigned SET_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETUP_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               we_l_q, we_l_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic               dr_oe_q, dr_oe_d;

    // Next state, counters, latched request and next-cycle output values
    always_comb begin
        state_d    = state_q;
        set_cnt_d  = set_cnt_q;
        wait_cnt_d = wait_cnt_q;
        we_l_d     = we_l_q;
        mem_addr_d = mem_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d    = S_SETUP;
                    mem_addr_d = addr;
                    we_l_d     = we;
                    set_cnt_d  = '0;
                    wait_cnt_d = '0;
                end
            end
            S_SETUP: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d    = S_ACCESS;
                    wait_cnt_d = '0;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            S_ACCESS: begin
                // Ready takes priority over the final timeout cycle
                if (mem_rdy) begin
                    state_d = S_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE) || (state_d == S_ERR);
        err_d    = (state_d == S_ERR);
        mem_rd_d = (state_d == S_ACCESS) && !we_l_d;
        mem_wr_d = (state_d == S_ACCESS) && we_l_d;
        dr_oe_d  = ((state_d == S_SETUP) || (state_d == S_ACCESS)) && we_l_d;
    end

    // State and registered outputs; async reset abandons any transfer silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            set_cnt_q  <= '0;
            wait_cnt_q <= '0;
            we_l_q     <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            dr_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_cnt_q  <= set_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            we_l_q     <= we_l_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            dr_oe_q    <= dr_oe_d;
        end
    end

    // DR captures read data on the same edge memory signals ready
    assign load_dr  = (state_q == S_ACCESS) && mem_rdy && !we_l_q;

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign dr_oe    = dr_oe_q;

endmodule
